// File: rtl/idct_block.sv
// Inverse 2-D DCT over one SIZE x SIZE block.
// Row pass then column pass, one SIZE-term dot product per clock, using SIZE
// parallel multiplier lanes. Coefficients in, level-shifted clamped pixels out.

// One multiplier lane: cosine weight times data operand, full-width signed product.
module idct_lane #(
    parameter int KW = 14,
    parameter int DW = 14
) (
    input  logic signed [KW-1:0]    k,
    input  logic signed [DW-1:0]    d,
    output logic signed [KW+DW-1:0] p
);
    assign p = (KW+DW)'(k) * (KW+DW)'(d);
endmodule

module idct_block #(
    parameter int SIZE        = 4,
    parameter int COEF_W      = 12,
    parameter int FRAC        = 12,
    parameter int LEVEL_SHIFT = 128
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SIZE-1:0][SIZE-1:0][COEF_W-1:0] coef,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [SIZE-1:0][SIZE-1:0][7:0]        pix,
    output logic                                  busy
);
    localparam int LG = $clog2(SIZE);
    localparam int IW = 2 * LG;
    localparam int KW = FRAC + 2;
    localparam int TW = COEF_W + 2;
    localparam int PW = KW + TW;
    // lane sum grows by LG bits; two spare bits for rounding and level shift
    localparam int SW = PW + LG + 2;
    localparam logic [IW-1:0]        LAST   = '1;
    localparam logic signed [SW-1:0] RND    = SW'(2 ** (FRAC - 1));
    localparam logic signed [SW-1:0] LSHIFT = SW'(LEVEL_SHIFT);
    localparam logic signed [SW-1:0] PMAX   = SW'(255);
    localparam longint SQRT_HALF_Q30 = 64'd759250125;

    // cos(m*pi/16) in Q30 for m = 0..8; every basis angle for N <= 8 folds onto these
    function automatic longint cosq(input int m);
        case (m)
            0:       cosq = 64'd1073741824;
            1:       cosq = 64'd1053110176;
            2:       cosq = 64'd992008094;
            3:       cosq = 64'd892783698;
            4:       cosq = 64'd759250125;
            5:       cosq = 64'd596538995;
            6:       cosq = 64'd410903207;
            7:       cosq = 64'd209476638;
            default: cosq = 64'd0;
        endcase
    endfunction

    // K[k][n] = round(c(k) * cos((2n+1)k*pi/2N) * 2^FRAC), evaluated at elaboration
    function automatic logic [KW-1:0] kval(input int k, input int n);
        longint cs, p, kv;
        int     m, e;
        logic   neg;
        m   = ((2 * n + 1) * k * (8 / SIZE)) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        // c(k)^2 = 2^-e; odd e needs a sqrt(1/2) factor
        e  = (k == 0) ? LG : LG - 1;
        cs = (e % 2 == 0) ? (longint'(1) << (30 - e / 2)) : (SQRT_HALF_Q30 >>> ((e - 1) / 2));
        p  = cosq(m) * cs;
        kv = (p + (longint'(1) << (59 - FRAC))) >>> (60 - FRAC);
        return neg ? KW'(-kv) : KW'(kv);
    endfunction

    typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

    state_t                                state;
    logic [IW-1:0]                         idx;
    logic [LG-1:0]                         ri, cj;
    logic                                  accept;
    logic [SIZE-1:0][SIZE-1:0][KW-1:0]     krom;
    logic [SIZE-1:0][SIZE-1:0][COEF_W-1:0] yreg;
    logic [SIZE-1:0][SIZE-1:0][TW-1:0]     treg;
    logic signed [KW-1:0]                  lk   [SIZE];
    logic signed [TW-1:0]                  ld   [SIZE];
    logic signed [PW-1:0]                  lp   [SIZE];
    logic signed [SW-1:0]                  psum [SIZE+1];
    logic signed [SW-1:0]                  rs, xs;
    logic [7:0]                            pv;

    for (genvar k = 0; k < SIZE; k++) begin : g_krow
        for (genvar n = 0; n < SIZE; n++) begin : g_kcol
            assign krom[k][n] = kval(k, n);
        end
    end

    // ROW walks (u,j), COL walks (i,j); both row-major in idx
    assign ri     = idx[IW-1:LG];
    assign cj     = idx[LG-1:0];
    assign accept = (state == IDLE) && in_valid && in_ready;

    // ROW lane v: K[v][j] * Y[u][v]; COL lane u: K[u][i] * T[u][j]
    assign psum[0] = '0;
    for (genvar l = 0; l < SIZE; l++) begin : g_lane
        assign lk[l] = (state == COL) ? $signed(krom[l][ri]) : $signed(krom[l][cj]);
        assign ld[l] = (state == COL) ? $signed(treg[l][cj]) : TW'($signed(yreg[ri][l]));
        idct_lane #(.KW(KW), .DW(TW)) u_lane (.k(lk[l]), .d(ld[l]), .p(lp[l]));
        assign psum[l+1] = psum[l] + SW'(lp[l]);
    end

    // round half up, then level shift for the pixel path
    assign rs = (psum[SIZE] + RND) >>> FRAC;
    assign xs = rs + LSHIFT;

    // clamp the shifted result to an 8-bit pixel
    always_comb begin
        pv = xs[7:0];
        if (xs[SW-1])
            pv = 8'd0;
        else if (xs > PMAX)
            pv = 8'd255;
    end

    // control FSM with registered handshake and busy outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= ROW;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ROW: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) state <= COL;
                end
                COL: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // datapath storage: coefficient latch, row-pass T buffer, output pixels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yreg <= '0;
            treg <= '0;
            pix  <= '0;
        end else begin
            if (accept)         yreg <= coef;
            if (state == ROW)   treg[ri][cj] <= rs[TW-1:0];
            if (state == COL)   pix[ri][cj]  <= pv;
        end
    end
endmodule

// File: tb/tb_idct_block.sv
// Directed bench for idct_block (SIZE=4): hand-computed pixel blocks,
// latency, handshake, stall and mid-block reset behaviour.
module tb_idct_block;
    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0][3:0][11:0]   coef;
    logic                    out_valid;
    logic                    out_ready;
    logic [3:0][3:0][7:0]    pix;
    logic                    busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    idct_block dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .coef(coef), .out_valid(out_valid), .out_ready(out_ready), .pix(pix), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every row reads a,b,c,d left to right (pix[i][0] is the low byte of row i)
    function automatic logic [127:0] rows_same(input logic [7:0] a, b, c, d);
        return {4{d, c, b, a}};
    endfunction

    // row i is filled entirely with the i-th argument
    function automatic logic [127:0] cols_same(input logic [7:0] a, b, c, d);
        return {{4{d}}, {4{c}}, {4{b}}, {4{a}}};
    endfunction

    // present a block, hold until acceptance edge, scramble coef, count clocks to out_valid
    task automatic run_block(input logic [3:0][3:0][11:0] c, output int lat);
        coef     = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        coef     = ~c;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0][3:0][11:0] blk, blk_b;
        logic [127:0]          snap, pa;
        logic                  ok_ov, ok_pix, ok_rdy;
        int                    lat, n, ta, acc_b;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; coef = '0;
        tick();
        tick();
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_in_ready",  128'(in_ready),  128'd0);
        chk("reset_busy",      128'(busy),      128'd0);
        chk("reset_pix",       pix,             128'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 128'(in_ready), 128'd1);

        // all-zero block: flat 128
        blk = '0;
        run_block(blk, lat);
        chk("zero_latency", 128'(lat), 128'd32);
        chk("zero_pix", pix, rows_same(8'd128, 8'd128, 8'd128, 8'd128));
        chk("zero_busy_done", 128'(busy), 128'd1);
        consume();
        chk("zero_consumed", 128'(out_valid), 128'd0);

        // DC only: 200 -> 178, 1000 -> clamp 255, -1000 -> clamp 0
        blk = '0; blk[0][0] = 12'd200;
        run_block(blk, lat);
        chk("dc200_latency", 128'(lat), 128'd32);
        chk("dc200_pix", pix, rows_same(8'd178, 8'd178, 8'd178, 8'd178));
        consume();
        blk = '0; blk[0][0] = 12'd1000;
        run_block(blk, lat);
        chk("dc_clamp_high", pix, rows_same(8'd255, 8'd255, 8'd255, 8'd255));
        consume();
        blk = '0; blk[0][0] = 12'(-1000);
        run_block(blk, lat);
        chk("dc_clamp_low", pix, rows_same(8'd0, 8'd0, 8'd0, 8'd0));
        consume();

        // first horizontal harmonic: every row 161,142,115,96
        blk = '0; blk[0][1] = 12'd100;
        run_block(blk, lat);
        chk("h1_pix", pix, rows_same(8'd161, 8'd142, 8'd115, 8'd96));
        consume();

        // back-to-back: A = horizontal harmonic, B = vertical harmonic
        blk   = '0; blk[0][1]   = 12'd100;
        blk_b = '0; blk_b[1][0] = 12'd100;
        coef = blk; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        coef = blk_b;
        n = 0; ta = -1; acc_b = -1; pa = '0;
        while (acc_b < 0 && n < 80) begin
            tick();
            n++;
            if (out_valid && ta < 0) begin
                ta = n;
                pa = pix;
            end
            if (in_ready) acc_b = n + 1;
        end
        tick();
        in_valid = 1'b0;
        coef = '0;
        chk("b2b_a_latency", 128'(ta), 128'd32);
        chk("b2b_a_pix", pa, rows_same(8'd161, 8'd142, 8'd115, 8'd96));
        chk("b2b_b_accept", 128'(acc_b), 128'd34);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("b2b_b_latency", 128'(lat), 128'd32);
        chk("b2b_b_pix", pix, cols_same(8'd161, 8'd142, 8'd114, 8'd95));
        tick();
        out_ready = 1'b0;
        chk("b2b_b_consumed", 128'(out_valid), 128'd0);

        // stall in DONE for 10 clocks with a competing in_valid
        blk = '0; blk[0][0] = 12'd200; blk[0][1] = 12'd100;
        run_block(blk, lat);
        chk("mix_pix", pix, rows_same(8'd211, 8'd192, 8'd165, 8'd146));
        snap = pix;
        coef = '0; coef[0][0] = 12'd1000; in_valid = 1'b1;
        ok_ov = 1'b1; ok_pix = 1'b1; ok_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!out_valid)    ok_ov  = 1'b0;
            if (pix !== snap)  ok_pix = 1'b0;
            if (in_ready)      ok_rdy = 1'b0;
        end
        chk("stall_out_valid_held", 128'(ok_ov),  128'd1);
        chk("stall_pix_stable",     128'(ok_pix), 128'd1);
        chk("stall_in_ready_low",   128'(ok_rdy), 128'd1);
        in_valid = 1'b0;
        consume();
        chk("stall_consumed", 128'(out_valid), 128'd0);
        chk("stall_idle_busy", 128'(busy), 128'd0);
        chk("pix_held_in_idle", pix, rows_same(8'd211, 8'd192, 8'd165, 8'd146));

        // reset pulse during the column pass aborts the block
        blk = '0; blk[0][0] = 12'd200;
        coef = blk; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        chk("midreset_out_valid", 128'(out_valid), 128'd0);
        chk("midreset_pix", pix, 128'd0);
        chk("midreset_busy", 128'(busy), 128'd0);
        chk("midreset_in_ready", 128'(in_ready), 128'd0);
        rst_n = 1'b1;
        tick();
        chk("midreset_ready_next", 128'(in_ready), 128'd1);
        blk = '0; blk[1][0] = 12'd100;
        run_block(blk, lat);
        chk("post_reset_latency", 128'(lat), 128'd32);
        chk("post_reset_pix", pix, cols_same(8'd161, 8'd142, 8'd114, 8'd95));
        consume();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
